serial_twos_decoder: RTL and testbench

- Receive end of the serial two's-complement link.
- Accepts an LSB-first bit stream that has been negated bit-serially (copy bits up to and including the first 1, invert all later bits).
- Undoes the negation on the fly and assembles the bits into a WIDTH-bit parallel word with a one-cycle valid strobe.
- Sits between the serial complementer's output and the parallel datapath consumer.

---
 rtl/serial_twos_decoder_pkg.sv | 17 +
 rtl/serial_negate_cell.sv | 27 ++
 rtl/serial_twos_decoder.sv | 97 +++++++++
 tb/tb_serial_twos_decoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_twos_decoder_pkg.sv
// Shared types and constants for the serial two's-complement receive path.
// Holds the FSM state encoding, default frame width and counter sizing.
package serial_twos_decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// Bit-serial negation cell: passes bits up to the first 1, inverts the rest.
// Ports: clk, rst (async low), clear (new frame), enable (consume bit), bitIn, r.
module serial_negate_cell (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic bitIn,
  output logic r
);

  logic seen_one;

  // A clear marks the current bit as bit 0, so the old history is ignored.
  assign r = bitIn ^ (seen_one & ~clear);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_one <= 1'b0;
    end else if (clear) begin
      seen_one <= enable & bitIn;
    end else if (enable) begin
      seen_one <= seen_one | bitIn;
    end
  end

endmodule

// File: rtl/serial_twos_decoder.sv
// Receives an LSB-first negated serial word, re-negates it, emits it in parallel.
// Ports: clk, rst, start, bitIn, bitValid -> dataOut, rawOut, dataValid, negOverflow, busy.
module serial_twos_decoder
  import serial_twos_decoder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bitIn,
  input  logic             bitValid,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] rawOut,
  output logic             dataValid,
  output logic             negOverflow,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rec;
  logic [WIDTH-1:0] raw;
  logic             r;
  logic             clear;
  logic             enable;
  logic [WIDTH-1:0] rec_base;
  logic [WIDTH-1:0] raw_base;
  logic [WIDTH-1:0] rec_next;
  logic [WIDTH-1:0] raw_next;

  // Idle cycles keep the cell cleared; start always begins a fresh frame.
  assign clear  = start | (state == IDLE);
  assign enable = bitValid & (start | (state == RECV));

  serial_negate_cell u_cell (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (enable),
    .bitIn  (bitIn),
    .r      (r)
  );

  assign rec_base = start ? '0 : rec;
  assign raw_base = start ? '0 : raw;
  assign rec_next = {r, rec_base[WIDTH-1:1]};
  assign raw_next = {bitIn, raw_base[WIDTH-1:1]};

  assign busy = (state == RECV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      count       <= '0;
      rec         <= '0;
      raw         <= '0;
      dataOut     <= '0;
      rawOut      <= '0;
      dataValid   <= 1'b0;
      negOverflow <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      if (start) begin
        // Start wins over a completing frame; the old frame is dropped.
        state <= RECV;
        if (bitValid) begin
          count <= CW'(1);
          rec   <= rec_next;
          raw   <= raw_next;
        end else begin
          count <= '0;
          rec   <= '0;
          raw   <= '0;
        end
      end else if (state == RECV && bitValid) begin
        if (count == LAST) begin
          state       <= IDLE;
          count       <= '0;
          dataOut     <= rec_next;
          rawOut      <= raw_next;
          dataValid   <= 1'b1;
          negOverflow <= (raw_next == MIN_NEG);
        end else begin
          count <= count + CW'(1);
          rec   <= rec_next;
          raw   <= raw_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_twos_decoder.sv
// Directed bench for serial_twos_decoder at WIDTH=8.
// Hand-computed vectors; all checks go through one task.
module tb_serial_twos_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bitIn = 1'b0;
  logic       bitValid = 1'b0;
  logic [7:0] dataOut;
  logic [7:0] rawOut;
  logic       dataValid;
  logic       negOverflow;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;
  int s0;

  serial_twos_decoder #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bitIn       (bitIn),
    .bitValid    (bitValid),
    .dataOut     (dataOut),
    .rawOut      (rawOut),
    .dataValid   (dataValid),
    .negOverflow (negOverflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dataValid === 1'b1) strobes++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic v);
    start = s;
    bitIn = b;
    bitValid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Sends one 8-bit frame; optional stall of n cycles after bit index k.
  task automatic send_frame(input logic [7:0] w,
                            input int k, input int n);
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, w[i], 1'b1);
      if (i == k) begin
        for (int j = 0; j < n; j++) drive(1'b0, 1'b0, 1'b0);
      end
    end
    start = 1'b0;
    bitIn = 1'b0;
    bitValid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_dout", dataOut, 8'h00);
    chk("rst_raw", rawOut, 8'h00);
    chk("rst_dv", dataValid, 1'b0);
    chk("rst_ovf", negOverflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 0xFB -> 0x05
    s0 = strobes;
    drive(1'b1, 1'b1, 1'b1);
    chk("fb_busy", busy, 1'b1);
    for (int i = 1; i < 8; i++) drive(1'b0, (i != 2), 1'b1);
    bitValid = 1'b0;
    chk("fb_dv", dataValid, 1'b1);
    chk("fb_dout", dataOut, 8'h05);
    chk("fb_raw", rawOut, 8'hFB);
    chk("fb_ovf", negOverflow, 1'b0);
    chk("fb_busy_fall", busy, 1'b0);
    idle();
    chk("fb_dv_drop", dataValid, 1'b0);
    chk("fb_strobes", strobes - s0, 1);

    // Most negative value
    send_frame(8'h80, -1, 0);
    chk("80_dv", dataValid, 1'b1);
    chk("80_dout", dataOut, 8'h80);
    chk("80_raw", rawOut, 8'h80);
    chk("80_ovf", negOverflow, 1'b1);
    idle();
    chk("80_hold", dataOut, 8'h80);
    chk("80_ovf_hold", negOverflow, 1'b1);

    // Zero
    send_frame(8'h00, -1, 0);
    chk("00_dv", dataValid, 1'b1);
    chk("00_dout", dataOut, 8'h00);
    chk("00_ovf", negOverflow, 1'b0);
    idle();

    // Stall three cycles after bit 3
    s0 = strobes;
    send_frame(8'hFB, 3, 3);
    chk("stall_dv", dataValid, 1'b1);
    chk("stall_dout", dataOut, 8'h05);
    chk("stall_raw", rawOut, 8'hFB);
    idle();
    chk("stall_strobes", strobes - s0, 1);

    // Partial frame of 0x12 then restart with 0xFF
    s0 = strobes;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, -1, 0);
    chk("rs_dv", dataValid, 1'b1);
    chk("rs_dout", dataOut, 8'h01);
    chk("rs_raw", rawOut, 8'hFF);
    idle();
    chk("rs_strobes", strobes - s0, 1);

    // Start coincident with 8th bit: new frame, no strobe
    s0 = strobes;
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    chk("coin_dv", dataValid, 1'b0);
    chk("coin_busy", busy, 1'b1);
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, 1'b1);
    bitValid = 1'b0;
    chk("coin_dout", dataOut, 8'h01);
    idle();
    chk("coin_strobes", strobes - s0, 1);

    // Async reset during bit 4
    s0 = strobes;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    bitIn = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_dout", dataOut, 8'h00);
    chk("arst_raw", rawOut, 8'h00);
    chk("arst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1);
    bitValid = 1'b0;
    chk("arst_ign_busy", busy, 1'b0);
    idle();
    chk("arst_strobes", strobes - s0, 0);

    // Back-to-back frames, no seenOne carry
    s0 = strobes;
    send_frame(8'h03, -1, 0);
    chk("b2b_dv1", dataValid, 1'b1);
    chk("b2b_dout1", dataOut, 8'hFD);
    send_frame(8'h01, -1, 0);
    chk("b2b_dv2", dataValid, 1'b1);
    chk("b2b_dout2", dataOut, 8'hFF);
    chk("b2b_raw2", rawOut, 8'h01);
    idle();
    chk("b2b_strobes", strobes - s0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
